// File: rtl/audio_sample_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// audio_sample_scheduler_pkg
//   Shared definitions for the audio sample scheduler: default sample and
//   counter widths, the silence value, the scheduler state encoding and two
//   small state-class helpers used by the top level.
// ---------------------------------------------------------------------------
package audio_sample_scheduler_pkg;

  localparam int AUDIO_W    = 32;
  localparam int UNDERRUN_W = 16;

  localparam logic [AUDIO_W-1:0] AUDIO_SILENCE = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  // States in which the sample-rate divider runs and ticks are produced.
  function automatic logic is_playing(input sched_state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

  // States in which new fetch requests may be raised.
  function automatic logic may_fetch(input sched_state_e s);
    return (s == ST_PRIME) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/audio_sample_scheduler_if.sv
// ---------------------------------------------------------------------------
// audio_sample_scheduler_if
//   Fetch handshake between the scheduler (master) and the sample source
//   (slave).
//   fetch_req  : master -> slave, request one sample; held until acked
//   fetch_ack  : slave -> master, fetch_data is valid in this same cycle
//   fetch_data : slave -> master, W-bit sample
// ---------------------------------------------------------------------------
interface audio_sample_scheduler_if
  import audio_sample_scheduler_pkg::*;
#(
  parameter int W = AUDIO_W
) ();

  logic         fetch_req;
  logic         fetch_ack;
  logic [W-1:0] fetch_data;

  modport master (
    output fetch_req,
    input  fetch_ack,
    input  fetch_data
  );

  modport slave (
    input  fetch_req,
    output fetch_ack,
    output fetch_data
  );

endinterface

// File: rtl/audio_sample_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
//   Synchronous prefetch FIFO for audio samples. Power-of-two depth with
//   naturally wrapping read/write pointers and a count one bit wider than
//   the pointers so that "full" is representable. A push and a pop in the
//   same cycle both take effect and leave the count unchanged.
// Ports
//   c           clock
//   r           synchronous active-high reset (flushes pointers and count)
//   push_i      write push_data_i at the tail
//   push_data_i sample to store
//   pop_i       drop the head entry (ignored when empty)
//   pop_data_o  current head entry (valid when !empty_o)
//   count_o     number of stored entries, 0..DEPTH
//   empty_o     count_o == 0
//   full_o      count_o == DEPTH
// ---------------------------------------------------------------------------
module sample_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                    c,
  input  logic                    r,
  input  logic                    push_i,
  input  logic [W-1:0]            push_data_i,
  input  logic                    pop_i,
  output logic [W-1:0]            pop_data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o,
  output logic                    full_o
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == DEPTH_C);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees a slot in the
  // same cycle; otherwise it is dropped rather than corrupting the head.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge c) begin
    if (r) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge c) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/audio_sample_scheduler.sv
// ---------------------------------------------------------------------------
// audio_sample_scheduler
//   Prefetches samples from the sample source over a req/ack handshake into
//   a small FIFO and presents one sample per sample-rate tick on x. The tick
//   is derived from clock c by a fixed divider. Empty-FIFO ticks while
//   playing emit SILENCE and are counted as underruns.
// Ports
//   c          clock, all logic on posedge
//   r          synchronous active-high reset
//   en         start request pulse, honoured only in IDLE
//   stop       stop request pulse, honoured in PRIME/RUN
//   fetch      fetch handshake (master side): fetch_req/fetch_ack/fetch_data
//   x          current output sample, held between ticks
//   x_valid    one-cycle strobe, x was updated this cycle
//   busy       scheduler is not IDLE
//   underruns  saturating underrun count, cleared only by r
// ---------------------------------------------------------------------------
module audio_sample_scheduler
  import audio_sample_scheduler_pkg::*;
#(
  parameter int           W           = AUDIO_W,
  parameter int           DEPTH       = 4,
  parameter int           PRIME_LEVEL = 4,
  parameter int           DIV         = 16,
  parameter logic [W-1:0] SILENCE     = W'(AUDIO_SILENCE)
) (
  input  logic                    c,
  input  logic                    r,
  input  logic                    en,
  input  logic                    stop,
  audio_sample_scheduler_if.master fetch,
  output logic [W-1:0]            x,
  output logic                    x_valid,
  output logic                    busy,
  output logic [UNDERRUN_W-1:0]   underruns
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              DW       = $clog2(DIV);
  localparam logic [AW:0]     DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     PRIME_C  = (AW+1)'(PRIME_LEVEL);
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);

  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (&v) ? v : v + UNDERRUN_W'(1);
  endfunction

  sched_state_e            state_q;
  sched_state_e            state_d;
  logic                    req_q;
  logic                    req_d;
  logic [DW-1:0]           div_q;
  logic [DW-1:0]           div_d;
  logic [W-1:0]            x_q;
  logic [W-1:0]            x_d;
  logic                    x_valid_q;
  logic                    x_valid_d;
  logic [UNDERRUN_W-1:0]   underruns_q;
  logic [UNDERRUN_W-1:0]   underruns_d;

  logic                    tick;
  logic                    push;
  logic                    pop;
  logic                    underrun_tick;
  logic [W-1:0]            fifo_head;
  logic [AW:0]             fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;

  // req_q doubles as the "request outstanding" flag: a sample is in flight
  // exactly while the request is high and not yet acknowledged.
  assign push = req_q && fetch.fetch_ack;

  sample_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .c           (c),
    .r           (r),
    .push_i      (push),
    .push_data_i (fetch.fetch_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Next-state, divider, handshake and output selection
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    div_d         = '0;
    x_d           = x_q;
    x_valid_d     = 1'b0;
    underrun_tick = 1'b0;
    pop           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        // stop takes priority over a same-cycle transition to RUN
        if (stop)                         state_d = ST_DRAIN;
        else if (fifo_count >= PRIME_C)   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !req_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tick = is_playing(state_q) && (div_q == DIV_LAST);

    // Divider restarts from zero whenever playback (re)starts or ends.
    if (is_playing(state_q) && is_playing(state_d)) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end

    // An open request stays up until acked. A new one is only raised when
    // nothing is outstanding, so count + outstanding < DEPTH reduces to
    // count < DEPTH here. A stop this cycle suppresses the new request.
    if (req_q) begin
      req_d = !fetch.fetch_ack;
    end else begin
      req_d = may_fetch(state_q) && !stop && (fifo_count < DEPTH_C);
    end

    if (tick && !fifo_empty) begin
      pop       = 1'b1;
      x_d       = fifo_head;
      x_valid_d = 1'b1;
    end else if (tick && (state_q == ST_RUN)) begin
      // Empty in RUN is an underrun; empty in DRAIN is simply the end.
      x_d           = SILENCE;
      x_valid_d     = 1'b1;
      underrun_tick = 1'b1;
    end
  end

  assign underruns_d = underrun_tick ? sat_inc(underruns_q) : underruns_q;

  // Register stage
  always_ff @(posedge c) begin
    if (r) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      div_q       <= '0;
      x_q         <= SILENCE;
      x_valid_q   <= 1'b0;
      underruns_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      div_q       <= div_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      underruns_q <= underruns_d;
      // The request/count accounting keeps one slot free for every
      // outstanding request, so an ack can never land on a full FIFO.
      assert (!(push && fifo_full));
    end
  end

  assign fetch.fetch_req = req_q;
  assign x               = x_q;
  assign x_valid         = x_valid_q;
  assign busy            = (state_q != ST_IDLE);
  assign underruns       = underruns_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
module tb_audio_sample_scheduler;
  import audio_sample_scheduler_pkg::*;

  localparam int W   = 32;
  localparam int DIV = 16;

  logic          c = 1'b0;
  logic          r;
  logic          en;
  logic          stop;
  logic [W-1:0]  x;
  logic          x_valid;
  logic          busy;
  logic [15:0]   underruns;

  audio_sample_scheduler_if #(.W(W)) ifc ();

  audio_sample_scheduler #(
    .W           (W),
    .DEPTH       (4),
    .PRIME_LEVEL (4),
    .DIV         (DIV),
    .SILENCE     (32'h0)
  ) dut (
    .c         (c),
    .r         (r),
    .en        (en),
    .stop      (stop),
    .fetch     (ifc),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .underruns (underruns)
  );

  always #5 c = ~c;

  // Sample source: either an auto-acking model (ack two clocks after the
  // request is seen, data 0x11, 0x22, ...) or manual ack from the sequence.
  logic          src_on;
  logic          src_ack;
  logic [W-1:0]  src_data;
  logic [W-1:0]  src_next;
  int            src_wait;
  logic          man_ack;
  logic [W-1:0]  man_data;

  assign ifc.fetch_ack  = src_on ? src_ack  : man_ack;
  assign ifc.fetch_data = src_on ? src_data : man_data;

  initial begin
    src_ack  = 1'b0;
    src_data = '0;
    src_next = 32'h11;
    src_wait = 0;
    forever begin
      @(negedge c);
      src_ack = 1'b0;
      if (src_on && ifc.fetch_req) begin
        if (src_wait == 1) begin
          src_ack  = 1'b1;
          src_data = src_next;
          src_next = src_next + 32'h11;
          src_wait = 0;
        end else begin
          src_wait++;
        end
      end else begin
        src_wait = 0;
      end
    end
  end

  // Bus monitor
  int   req_rises = 0;
  int   xv_cnt    = 0;
  int   req_viol  = 0;
  logic req_prev  = 1'b0;
  logic ack_hit   = 1'b0;

  always @(posedge c) begin
    if (ack_hit && ifc.fetch_req) req_viol++;
    ack_hit = ifc.fetch_req && ifc.fetch_ack;
    if (ifc.fetch_req && !req_prev) req_rises++;
    req_prev = ifc.fetch_req;
    if (x_valid) xv_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Wait (bounded) for the next x_valid strobe; check value and cycle gap.
  task automatic expect_xv(input string tag, input logic [31:0] exp_x, input int exp_gap);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (x_valid !== 1'b1 && n < 64);
    chk({tag, "_seen"}, {31'd0, x_valid}, 32'd1);
    chk({tag, "_x"}, x, exp_x);
    if (exp_gap > 0) chk({tag, "_gap"}, n, exp_gap);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, ifc.fetch_req}, 32'd0);
    chk({tag, "_x"},     x, 32'd0);
    chk({tag, "_xv"},    {31'd0, x_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_under"}, {16'd0, underruns}, 32'd0);
  endtask

  int snap_rises;
  int snap_xv;

  initial begin
    r        = 1'b1;
    en       = 1'b0;
    stop     = 1'b0;
    src_on   = 1'b0;
    man_ack  = 1'b0;
    man_data = '0;
    steps(3);
    chk_reset_outputs("rst");
    r = 1'b0;
    step();

    // 1: prime with 0x11..0x44, first sample DIV clocks after RUN
    en = 1'b1;
    step();
    en     = 1'b0;
    src_on = 1'b1;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    expect_xv("t1_s11", 32'h11, 29);
    expect_xv("t1_s22", 32'h22, 16);
    step();
    chk("t1_strobe", {31'd0, x_valid}, 32'd0);

    // 2: source stalls, queue drains, then underruns, then recovery
    src_on = 1'b0;
    expect_xv("t2_s33", 32'h33, 15);
    expect_xv("t2_s44", 32'h44, 16);
    expect_xv("t2_s55", 32'h55, 16);
    for (int k = 1; k <= 3; k++) begin
      expect_xv($sformatf("t2_ur%0d", k), 32'h0, 16);
      chk($sformatf("t2_cnt%0d", k), {16'd0, underruns}, k);
    end
    src_on = 1'b1;
    expect_xv("t2_s66", 32'h66, 16);
    chk("t2_cnt_hold", {16'd0, underruns}, 32'd3);

    // 3: stop with 3 queued + 1 outstanding, drain to IDLE
    step();
    chk("t3_req_out", {31'd0, ifc.fetch_req}, 32'd1);
    stop = 1'b1;
    step();
    stop       = 1'b0;
    snap_rises = req_rises;
    expect_xv("t3_s77", 32'h77, 14);
    expect_xv("t3_s88", 32'h88, 16);
    expect_xv("t3_s99", 32'h99, 16);
    expect_xv("t3_sAA", 32'hAA, 16);
    steps(2);
    chk("t3_idle", {31'd0, busy}, 32'd0);
    snap_xv = xv_cnt;
    steps(40);
    chk("t3_no_xv", xv_cnt, snap_xv);
    chk("t3_no_req", req_rises, snap_rises);
    chk("t3_x_hold", x, 32'hAA);
    chk("t3_busy", {31'd0, busy}, 32'd0);

    // 4: ack while idle is ignored; ack coincident with req rise pushes once
    src_on   = 1'b0;
    man_ack  = 1'b1;
    man_data = 32'hDEAD0001;
    steps(3);
    chk("t4_idle_req", {31'd0, ifc.fetch_req}, 32'd0);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("t4_req_lo", {31'd0, ifc.fetch_req}, 32'd0);
    man_data = 32'hA0;
    step();
    chk("t4_req_rise", {31'd0, ifc.fetch_req}, 32'd1);
    step();
    chk("t4_req_drop", {31'd0, ifc.fetch_req}, 32'd0);
    man_ack = 1'b0;
    src_on  = 1'b1;
    expect_xv("t4_sA0", 32'hA0, 26);

    // 5: reset mid-RUN with a request pending, late ack ignored, restart
    src_on = 1'b0;
    step();
    chk("t5_req", {31'd0, ifc.fetch_req}, 32'd1);
    r = 1'b1;
    step();
    r = 1'b0;
    chk_reset_outputs("t5_rst");
    man_ack  = 1'b1;
    man_data = 32'hBAD00000;
    steps(2);
    chk("t5_late_req", {31'd0, ifc.fetch_req}, 32'd0);
    man_ack = 1'b0;
    src_on  = 1'b1;
    en = 1'b1;
    step();
    en = 1'b0;
    expect_xv("t5_sEE", 32'hEE, 29);

    // 6: underrun counter saturation
    src_on = 1'b0;
    force dut.underruns_d = 16'hFFFE;
    step();
    release dut.underruns_d;
    chk("t6_forced", {16'd0, underruns}, 32'h0000FFFE);
    expect_xv("t6_sFF", 32'hFF, 15);
    expect_xv("t6_s110", 32'h110, 16);
    expect_xv("t6_s121", 32'h121, 16);
    for (int k = 1; k <= 3; k++) begin
      expect_xv($sformatf("t6_ur%0d", k), 32'h0, 16);
      chk($sformatf("t6_sat%0d", k), {16'd0, underruns}, 32'h0000FFFF);
    end

    chk("req_after_ack", req_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
